// File: rtl/mem_responder.sv
// Memory-side responder: one req/ack (4-phase) transaction at a time, fixed wait states, then array access.
// Optional MEM_RESP_ERR_EN adds out-of-range detection and the err output.
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef MEM_RESP_ERR_EN
    ,
    output logic              err
`endif
);

    // state    | meaning
    // ST_IDLE  | waiting for req; latches we/addr/wdata and loads the wait counter
    // ST_WAIT  | counting down wait states
    // ST_ACCESS| single-cycle array write or read
    // ST_ACK   | transaction done; held until req falls
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_rd;
    logic                in_range;
    logic                mem_we;

    // Without error checking the address wraps modulo DEPTH.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_idx_full
            assign mem_idx = IDX_W'(addr_q);
        end else begin : g_idx_mod
            assign mem_idx = IDX_W'(addr_q % ADDR_W'(DEPTH));
        end
    endgenerate

`ifdef MEM_RESP_ERR_EN
    assign in_range = (32'(addr_q) < DEPTH);
    assign err      = err_q;
`else
    assign in_range = 1'b1;
`endif

    assign mem_rd = mem_q[mem_idx];
    assign mem_we = (state_q == ST_ACCESS) && we_q && in_range;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        // Outputs are registered from the current state, so they trail it by one cycle.
        ack_d   = (state_q == ST_ACK);
        busy_d  = (state_q == ST_WAIT) || (state_q == ST_ACCESS);
        err_d   = (state_q == ST_ACK) && !in_range;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = in_range ? mem_rd : '0;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (WAIT_STATES 1, 0, 3); MEM_RESP_ERR_EN adds the err cases.
module tb_mem_responder;

    localparam int N = 3;
`ifdef MEM_RESP_ERR_EN
    localparam int DEPTH0 = 12;
`else
    localparam int DEPTH0 = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_v   [N];
    logic       req_v   [N];
    logic       we_v    [N];
    logic [3:0] addr_v  [N];
    logic [7:0] wdata_v [N];
    logic [7:0] rdata_v [N];
    logic       ack_v   [N];
    logic       busy_v  [N];
`ifdef MEM_RESP_ERR_EN
    logic       err_v   [N];
`endif
    logic       ack_prev [N];

    typedef struct {
        int         g;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            mem_responder #(
                .DATA_W(8),
                .ADDR_W(4),
                .DEPTH((g == 0) ? DEPTH0 : 16),
                .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
            ) u_dut (
                .clk(clk),
                .rst_n(rst_v[g]),
                .req(req_v[g]),
                .we(we_v[g]),
                .addr(addr_v[g]),
                .wdata(wdata_v[g]),
                .rdata(rdata_v[g]),
                .ack(ack_v[g]),
                .busy(busy_v[g])
`ifdef MEM_RESP_ERR_EN
                ,
                .err(err_v[g])
`endif
            );
        end
    endgenerate

    function automatic int ws(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rising ack consumes one expected response.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (ack_v[g] === 1'b1 && ack_prev[g] !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_ack: dut %0d raised ack with no pending request", g);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_dut", g, e.g);
                    check("sb_rdata", rdata_v[g], e.rdata);
`ifdef MEM_RESP_ERR_EN
                    check("sb_err", err_v[g], e.err);
`endif
                end
            end
            ack_prev[g] <= ack_v[g];
        end
    end

    task automatic push_exp(input int g, input logic [7:0] rd, input logic er);
        exp_t e;
        e.g = g;
        e.rdata = rd;
        e.err = er;
        sb_q.push_back(e);
    endtask

    // Full handshake; inputs are scrambled right after the latching edge.
    task automatic do_txn(input int g, input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input logic exp_err, input int hold);
        int n;
        bit busy_ok;
        bit hold_ok;
        push_exp(g, exp_rd, exp_err);
        req_v[g] = 1'b1;
        we_v[g] = w;
        addr_v[g] = a;
        wdata_v[g] = d;
        n = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                we_v[g] = ~w;
                addr_v[g] = ~a;
                wdata_v[g] = ~d;
            end
            if (ack_v[g] === 1'b1) break;
            if (busy_v[g] !== (n >= 2)) busy_ok = 1'b0;
        end
        check("latency", n - 1, ws(g) + 2);
        check("busy_during_wait", busy_ok, 1);
        check("busy_at_ack", busy_v[g], 0);
        hold_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (ack_v[g] !== 1'b1 || busy_v[g] !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) check("ack_hold", hold_ok, 1);
        req_v[g] = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_release", ack_v[g], 0);
    endtask

    // req dropped right after the latching edge: transaction completes, ack pulses once.
    task automatic pv_txn(input int g, input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd);
        int cnt;
        push_exp(g, exp_rd, 1'b0);
        req_v[g] = 1'b1;
        we_v[g] = w;
        addr_v[g] = a;
        wdata_v[g] = d;
        @(negedge clk);
        req_v[g] = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack_v[g] === 1'b1) cnt++;
        end
        check("pv_ack_pulse", cnt, 1);
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            rst_v[g] = 1'b0;
            req_v[g] = 1'b0;
            we_v[g] = 1'b0;
            addr_v[g] = 4'h0;
            wdata_v[g] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check("reset_ack", ack_v[g], 0);
            check("reset_busy", busy_v[g], 0);
            check("reset_rdata", rdata_v[g], 8'h00);
        end
        for (int g = 0; g < N; g++) rst_v[g] = 1'b1;
        @(negedge clk);

        // WAIT_STATES=1
        do_txn(0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, 0);
        do_txn(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, 0);
        check("rdata_hold", rdata_v[0], 8'hA5);
        do_txn(0, 1'b1, 4'd5, 8'h77, 8'hA5, 1'b0, 5);
        do_txn(0, 1'b0, 4'd5, 8'h00, 8'h77, 1'b0, 0);
        pv_txn(0, 1'b1, 4'd7, 8'h42, 8'h77);
        do_txn(0, 1'b0, 4'd7, 8'h00, 8'h42, 1'b0, 0);
`ifdef MEM_RESP_ERR_EN
        do_txn(0, 1'b1, 4'd14, 8'h11, 8'h42, 1'b1, 0);
        do_txn(0, 1'b0, 4'd14, 8'h00, 8'h00, 1'b1, 0);
        do_txn(0, 1'b1, 4'd11, 8'h99, 8'h00, 1'b0, 0);
        do_txn(0, 1'b0, 4'd11, 8'h00, 8'h99, 1'b0, 0);
`endif

        // WAIT_STATES=0
        do_txn(1, 1'b1, 4'd15, 8'h3C, 8'h00, 1'b0, 0);
        do_txn(1, 1'b0, 4'd15, 8'h00, 8'h3C, 1'b0, 0);

        // WAIT_STATES=3: reset aborts a write in WAIT
        do_txn(2, 1'b1, 4'd2, 8'h5A, 8'h00, 1'b0, 0);
        do_txn(2, 1'b0, 4'd2, 8'h00, 8'h5A, 1'b0, 0);
        req_v[2] = 1'b1;
        we_v[2] = 1'b1;
        addr_v[2] = 4'd2;
        wdata_v[2] = 8'hFF;
        repeat (2) @(negedge clk);
        check("busy_before_rst", busy_v[2], 1);
        rst_v[2] = 1'b0;
        req_v[2] = 1'b0;
        #1;
        check("rst_async_ack", ack_v[2], 0);
        check("rst_async_busy", busy_v[2], 0);
        check("rst_async_rdata", rdata_v[2], 8'h00);
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(negedge clk);
        do_txn(2, 1'b0, 4'd2, 8'h00, 8'h5A, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
